// File: rtl/onewire_pkg.sv
// ---------------------------------------------------------------------------
// onewire_pkg
//   Shared definitions for the 1-Wire time-slot engine.
//   - Standard-speed slot timing in microseconds (converted to clock cycles
//     by the engine using its CLK_MHZ parameter).
//   - Slot mode encoding: OW_READ = 0, OW_WRITE = 1.
//   - Engine state encoding: IDLE, SLOT, FINISH.
// ---------------------------------------------------------------------------
package onewire_pkg;

  // Standard-speed slot timing, in microseconds.
  localparam int unsigned T_SLOT_US_STD   = 70;  // full slot incl. recovery
  localparam int unsigned T_LOW_RD_US_STD = 6;   // read-slot pull-down
  localparam int unsigned T_SAMPLE_US_STD = 15;  // read sample point
  localparam int unsigned T_LOW_W1_US_STD = 6;   // write-1 pull-down
  localparam int unsigned T_LOW_W0_US_STD = 60;  // write-0 pull-down

  typedef enum logic {
    OW_READ  = 1'b0,
    OW_WRITE = 1'b1
  } ow_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT   = 2'd1,
    FINISH = 2'd2
  } ow_state_e;

  // Microseconds to clock cycles.
  function automatic int unsigned us_to_cycles(input int unsigned us,
                                               input int unsigned clk_mhz);
    return us * clk_mhz;
  endfunction

endpackage

// File: rtl/onewire_slot_timer.sv
// ---------------------------------------------------------------------------
// onewire_slot_timer
//   Slot counter for the 1-Wire engine. The engine supplies its next-cycle
//   view (will a slot be running, does a new slot begin, pull-down length and
//   whether reads are sampled), so drive_low and sample_pt come straight out
//   of flops and line up exactly with the slot counter value they describe.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   active_d_i      a slot is running in the next cycle
//   restart_d_i     the next cycle is slot cycle 0
//   sample_en_d_i   the running slot is a read slot
//   low_len_d_i     pull-down length (cycles) of the slot in the next cycle
//   drive_low_o     registered bus pull-down request
//   sample_pt_o     registered one-cycle strobe at the sample offset
//   slot_end_o      current cycle is the last cycle of a slot
// ---------------------------------------------------------------------------
module onewire_slot_timer #(
  parameter int unsigned SLOT_C = 1890,
  parameter int unsigned SMP_C  = 405,
  parameter int unsigned CW     = $clog2(SLOT_C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active_d_i,
  input  logic          restart_d_i,
  input  logic          sample_en_d_i,
  input  logic [CW-1:0] low_len_d_i,
  output logic          drive_low_o,
  output logic          sample_pt_o,
  output logic          slot_end_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          drive_q;
  logic          sample_q;

  // Counter parks at zero whenever no slot is running.
  always_comb begin
    cnt_d = '0;
    if (active_d_i && !restart_d_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      drive_q  <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      drive_q  <= active_d_i && (cnt_d < low_len_d_i);
      sample_q <= active_d_i && sample_en_d_i && (cnt_d == CW'(SMP_C));
    end
  end

  assign drive_low_o = drive_q;
  assign sample_pt_o = sample_q;
  assign slot_end_o  = (cnt_q == CW'(SLOT_C - 1));

endmodule

// File: rtl/onewire_bit_engine.sv
// ---------------------------------------------------------------------------
// onewire_bit_engine
//   1-Wire time-slot engine: runs 1..MAX_BITS read or write slots, LSB
//   first, back to back, under a start/busy/done handshake. It drives the
//   open-drain pull-down request and samples the (already synchronised) bus
//   itself, assembling read data into rdata.
//
//   Handshake: start is a one-cycle request honoured only in IDLE; mode,
//   nbits (clamped to MAX_BITS) and wdata are captured then. busy is high
//   for exactly nbits slot lengths starting the cycle after the accepted
//   start; done pulses for one cycle right after the last slot cycle. A zero
//   slot count yields a lone done pulse two cycles after start. Requests
//   outside IDLE are dropped, not queued.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle transfer request
//   mode         0 = read slots, 1 = write slots
//   nbits        number of slots
//   wdata        write data, bit 0 first
//   ow_in        synchronised bus level
//   drive_low    1 = pull the bus low
//   busy         transfer in progress
//   done         one-cycle completion pulse
//   rdata        read result, bit i from slot i
//   sample       one-cycle strobe at each read sample point
// ---------------------------------------------------------------------------
module onewire_bit_engine
  import onewire_pkg::*;
#(
  parameter int unsigned CLK_MHZ     = 27,
  parameter int unsigned MAX_BITS    = 64,
  parameter int unsigned T_SLOT_US   = T_SLOT_US_STD,
  parameter int unsigned T_LOW_RD_US = T_LOW_RD_US_STD,
  parameter int unsigned T_SAMPLE_US = T_SAMPLE_US_STD,
  parameter int unsigned T_LOW_W1_US = T_LOW_W1_US_STD,
  parameter int unsigned T_LOW_W0_US = T_LOW_W0_US_STD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic [$clog2(MAX_BITS+1)-1:0] nbits,
  input  logic [MAX_BITS-1:0]           wdata,
  input  logic                          ow_in,
  output logic                          drive_low,
  output logic                          busy,
  output logic                          done,
  output logic [MAX_BITS-1:0]           rdata,
  output logic                          sample
);

  localparam int unsigned NBW    = $clog2(MAX_BITS + 1);
  localparam int unsigned SLOT_C = us_to_cycles(T_SLOT_US,   CLK_MHZ);
  localparam int unsigned LRD_C  = us_to_cycles(T_LOW_RD_US, CLK_MHZ);
  localparam int unsigned SMP_C  = us_to_cycles(T_SAMPLE_US, CLK_MHZ);
  localparam int unsigned LW1_C  = us_to_cycles(T_LOW_W1_US, CLK_MHZ);
  localparam int unsigned LW0_C  = us_to_cycles(T_LOW_W0_US, CLK_MHZ);
  localparam int unsigned CW     = $clog2(SLOT_C);

  // The read pull-down must end before the sample point, which must fall
  // inside the slot; every pull-down must leave some recovery time (this
  // also keeps the pull-down lengths within the slot counter width).
  if (!((LRD_C < SMP_C) && (SMP_C < SLOT_C) &&
        (LW0_C < SLOT_C) && (LW1_C < SLOT_C))) begin : g_timing_bad
    $error("onewire_bit_engine: inconsistent slot timing parameters");
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  ow_state_e           state_q, state_d;
  ow_mode_e            mode_q, mode_d;
  logic [NBW-1:0]      nbits_q;
  logic [NBW-1:0]      bit_idx_q;
  logic [MAX_BITS-1:0] wsh_q, wsh_d;
  logic [MAX_BITS-1:0] rdata_q;
  logic                busy_q;
  logic                done_q;

  // Timer interface
  logic                restart_d;
  logic                active_d;
  logic [CW-1:0]       low_len_d;
  logic                slot_end;
  logic                sample_pt;
  logic                drive_low_t;

  logic [NBW-1:0]      nbits_cl;
  logic                last_slot;

  assign nbits_cl  = (nbits > NBW'(MAX_BITS)) ? NBW'(MAX_BITS) : nbits;
  assign last_slot = ((bit_idx_q + 1'b1) == nbits_q);

  // -------------------------------------------------------------------------
  // Next-state view. The timer registers its outputs from these so that
  // drive_low is already asserted in the first cycle of every slot.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wsh_d     = wsh_q;
    restart_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = ow_mode_e'(mode);
          wsh_d     = wdata;
          restart_d = 1'b1;
          state_d   = (nbits_cl == '0) ? FINISH : SLOT;
        end
      end
      SLOT: begin
        if (slot_end) begin
          restart_d = 1'b1;
          wsh_d     = wsh_q >> 1;
          if (last_slot) begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign active_d  = (state_d == SLOT);
  // Bit 0 of the shift register is always the bit of the slot about to run.
  assign low_len_d = (mode_d == OW_READ) ? CW'(LRD_C) :
                     (wsh_d[0] ? CW'(LW1_C) : CW'(LW0_C));

  onewire_slot_timer #(
    .SLOT_C (SLOT_C),
    .SMP_C  (SMP_C),
    .CW     (CW)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .active_d_i    (active_d),
    .restart_d_i   (restart_d),
    .sample_en_d_i (mode_d == OW_READ),
    .low_len_d_i   (low_len_d),
    .drive_low_o   (drive_low_t),
    .sample_pt_o   (sample_pt),
    .slot_end_o    (slot_end)
  );

  // -------------------------------------------------------------------------
  // FSM and data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= OW_READ;
      nbits_q   <= '0;
      bit_idx_q <= '0;
      wsh_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wsh_q   <= wsh_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            nbits_q   <= nbits_cl;
            bit_idx_q <= '0;
            rdata_q   <= '0;
            busy_q    <= (nbits_cl != '0);
          end
        end
        SLOT: begin
          // rdata was cleared at start and each bit is visited once, so
          // OR-ing the sampled level in is enough.
          if (sample_pt) begin
            rdata_q <= rdata_q | (MAX_BITS'(ow_in) << bit_idx_q);
          end
          if (slot_end) begin
            bit_idx_q <= bit_idx_q + 1'b1;
            if (last_slot) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        FINISH: begin
          // Coming from SLOT, done was raised on entry and is dropped here;
          // coming straight from IDLE (zero slots) it is raised here.
          done_q <= ~done_q;
        end
        default: ;
      endcase
    end
  end

  assign drive_low = drive_low_t;
  assign sample    = sample_pt;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_onewire_bit_engine.sv
// ---------------------------------------------------------------------------
// tb_onewire_bit_engine
//   Bench for onewire_bit_engine at CLK_MHZ = 3 so that full 64-slot
//   transfers stay short. A 1-Wire slave model answers read slots from
//   model_bits; a negedge monitor measures pulse widths, sample offsets,
//   busy length and done timing; expected rdata goes through exp_q.
// ---------------------------------------------------------------------------
module tb_onewire_bit_engine;

  localparam int CLK_MHZ = 3;
  localparam int MAXB    = 64;
  localparam int NBW     = $clog2(MAXB + 1);
  localparam int SLOT_C  = 70 * CLK_MHZ;
  localparam int LRD_C   = 6 * CLK_MHZ;
  localparam int SMP_C   = 15 * CLK_MHZ;
  localparam int LW1_C   = 6 * CLK_MHZ;
  localparam int LW0_C   = 60 * CLK_MHZ;
  localparam int LIMIT   = MAXB * SLOT_C + 50;

  // DUT signals
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            mode = 1'b0;
  logic [NBW-1:0]  nbits = '0;
  logic [MAXB-1:0] wdata = '0;
  logic            ow_in;
  logic            drive_low;
  logic            busy;
  logic            done;
  logic [MAXB-1:0] rdata;
  logic            sample;

  // Scoreboard and counters
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Slave model and monitor state
  logic [63:0] model_bits = '0;
  logic [5:0]  slot_sel;
  logic        prev_dl = 1'b0;
  int          cyc = 0;
  int          cyc_in_slot = 0;
  int          rise_cnt = 0;
  int          busy_cyc = 0;
  int          done_cnt = 0;
  int          done_at = 0;
  int          smp_cnt = 0;
  int          low_w[0:63];
  int          smp_off[0:63];

  onewire_bit_engine #(
    .CLK_MHZ  (CLK_MHZ),
    .MAX_BITS (MAXB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .nbits     (nbits),
    .wdata     (wdata),
    .ow_in     (ow_in),
    .drive_low (drive_low),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .sample    (sample)
  );

  // -------------------------------------------------------------------------
  // Clock / watchdog
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Open-drain bus: low while the master pulls, otherwise the slave's bit
  // for the slot in progress.
  assign slot_sel = (rise_cnt > 0) ? 6'(rise_cnt - 1) : 6'd0;
  assign ow_in    = drive_low ? 1'b0 : model_bits[slot_sel];

  // -------------------------------------------------------------------------
  // Monitor: counters restart when an idle-time start is seen.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    prev_dl <= drive_low;
    if (start && !busy && !rst) begin
      cyc         <= 0;
      cyc_in_slot <= 0;
      rise_cnt    <= 0;
      busy_cyc    <= 0;
      done_cnt    <= 0;
      done_at     <= 0;
      smp_cnt     <= 0;
      for (int k = 0; k < 64; k++) begin
        low_w[k]   <= 0;
        smp_off[k] <= -1;
      end
    end else begin
      cyc <= cyc + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (done_cnt == 0) done_at <= cyc + 1;
      end
      if (drive_low && !prev_dl) begin
        rise_cnt    <= rise_cnt + 1;
        cyc_in_slot <= 0;
        if (rise_cnt < 64) low_w[rise_cnt] <= 1;
      end else begin
        cyc_in_slot <= cyc_in_slot + 1;
        if (drive_low && rise_cnt > 0 && rise_cnt <= 64)
          low_w[rise_cnt-1] <= low_w[rise_cnt-1] + 1;
      end
      if (sample) begin
        smp_cnt <= smp_cnt + 1;
        if (rise_cnt > 0 && rise_cnt <= 64) smp_off[rise_cnt-1] <= cyc_in_slot + 1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Checker
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  task automatic start_txn(input logic m, input int nb, input logic [63:0] wd,
                           input logic [63:0] mdl);
    int          nb_eff;
    logic [63:0] one;
    logic [63:0] msk;
    nb_eff = (nb > MAXB) ? MAXB : nb;
    one    = 64'd1;
    msk    = (nb_eff >= 64) ? '1 : ((one << nb_eff) - 64'd1);
    model_bits = mdl;
    exp_q.push_back(m ? 64'd0 : (mdl & msk));
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    nbits = NBW'(nb);
    wdata = wd;
    @(posedge clk); #1;
    start = 1'b0;
    // Changing the request inputs after capture must not matter.
    mode  = ~m;
    nbits = NBW'($urandom_range(1, 64));
    wdata = ~wd;
  endtask

  task automatic finish_txn(input logic m, input int nb, input logic [63:0] wd);
    int          nb_eff;
    int          exp_done;
    logic [63:0] exp_r;
    nb_eff   = (nb > MAXB) ? MAXB : nb;
    exp_done = (nb_eff == 0) ? 2 : nb_eff * SLOT_C + 1;
    for (int i = 0; i < LIMIT && done_cnt == 0; i++) @(posedge clk);
    check("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (4) @(posedge clk);
    check("done_at", 64'(done_at), 64'(exp_done));
    check("done_cnt", 64'(done_cnt), 64'd1);
    check("busy_cyc", 64'(busy_cyc), 64'(nb_eff * SLOT_C));
    check("slots", 64'(rise_cnt), 64'(nb_eff));
    check("samples", 64'(smp_cnt), m ? 64'd0 : 64'(nb_eff));
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd1, 64'd0);
    end else begin
      exp_r = exp_q.pop_front();
      check("rdata", rdata, exp_r);
    end
    for (int k = 0; k < nb_eff; k++) begin
      check($sformatf("low_w[%0d]", k), 64'(low_w[k]),
            m ? (wd[k] ? 64'(LW1_C) : 64'(LW0_C)) : 64'(LRD_C));
      if (!m) check($sformatf("smp_off[%0d]", k), 64'(smp_off[k]), 64'(SMP_C));
    end
  endtask

  task automatic run_txn(input logic m, input int nb, input logic [63:0] wd,
                         input logic [63:0] mdl);
    start_txn(m, nb, wd, mdl);
    finish_txn(m, nb, wd);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int hit;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {60'd0, drive_low, busy, done, sample}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed transfers
    run_txn(1'b0, 8, 64'd0, 64'h00A5);                   // read 0xA5
    run_txn(1'b1, 8, 64'h3C, 64'hFFFF_FFFF_FFFF_FFFF);   // write 0x3C
    run_txn(1'b0, 0, 64'd0, 64'hFF);                     // zero slots
    run_txn(1'b0, 64, 64'd0, 64'h5555_5555_5555_5555);   // full width
    run_txn(1'b0, 70, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA);   // clamped to 64
    run_txn(1'b0, 1, 64'd0, 64'h1);                      // single slot

    // Start pulsed mid-transfer with different request: ignored
    start_txn(1'b0, 8, 64'd0, 64'h00A5);
    hit = 0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      @(posedge clk);
      if (rise_cnt == 3) hit = 1;
    end
    check("wait_slot2", 64'(hit), 64'd1);
    #1;
    start = 1'b1; mode = 1'b1; nbits = NBW'(2); wdata = '0;
    @(posedge clk); #1;
    start = 1'b0;
    finish_txn(1'b0, 8, 64'd0);

    // Reset at slot_cnt = 100 of slot 3
    start_txn(1'b0, 8, 64'd0, 64'h00A5);
    hit = 0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      @(posedge clk);
      if (rise_cnt == 4 && cyc_in_slot == 99) hit = 1;
    end
    check("wait_slot3", 64'(hit), 64'd1);
    check("pre_rst_rdata", rdata, 64'h5);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ctl", {61'd0, drive_low, busy, done}, 64'd0);
    check("rst_mid_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_front());
    repeat (2 * SLOT_C) @(posedge clk);
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_no_slots", 64'(rise_cnt), 64'd4);
    check("rst_busy", {63'd0, busy}, 64'd0);

    // Normal operation after reset
    run_txn(1'b0, 8, 64'd0, 64'h003C);

    // Random transfers
    for (int t = 0; t < 4; t++) begin
      logic        m;
      int          nb;
      logic [63:0] wd;
      logic [63:0] mdl;
      m   = 1'($urandom_range(0, 1));
      nb  = $urandom_range(1, 12);
      wd  = {$urandom, $urandom};
      mdl = {$urandom, $urandom};
      run_txn(m, nb, wd, mdl);
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
